// File: rtl/mmio_timer_if.sv
// mmio_timer_if
// Data-side load/store bus between the processor and the timer peripheral.
//   memwrite  : store strobe (master -> slave)
//   dataadr   : byte address (master -> slave)
//   writedata : store data (master -> slave)
//   readdata  : combinational load data (slave -> master)
//   sel       : window-hit flag for the top-level read mux (slave -> master)
interface mmio_timer_if;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        sel;

    modport master (
        output memwrite,
        output dataadr,
        output writedata,
        input  readdata,
        input  sel
    );

    modport slave (
        input  memwrite,
        input  dataadr,
        input  writedata,
        output readdata,
        output sel
    );
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer
// Memory-mapped timer with prescaler, 32-bit counter, compare match,
// optional auto-reload and a maskable interrupt. Occupies a 16-byte
// window at BASE_ADDR.
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : load/store bus (memwrite, dataadr, writedata, readdata, sel)
//   irq   : interrupt request, STATUS.match & CTRL.irq_en
// Register map (offset = dataadr[3:2]):
//   0x0 CTRL    bit0 en, bit1 autoreload, bit2 irq_en
//   0x4 COUNT   counter value, write loads it
//   0x8 COMPARE compare value
//   0xC STATUS  bit0 match, write-1-to-clear
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int          PRESC_DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    mmio_timer_if.slave  bus,
    output logic         irq
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESC_DIV - 1);

    logic        r_en;
    logic        r_autoreload;
    logic        r_irq_en;
    logic        r_match;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [15:0] r_presc;

    logic        w_sel;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_en_next;
    logic        w_tick;
    logic        w_hit;
    logic [31:0] w_readdata;
    logic        w_unused_addr_bits;

    // Byte-lane bits of the address do not select anything.
    assign w_unused_addr_bits = ^bus.dataadr[1:0];

    assign w_sel        = (bus.dataadr[31:4] == BASE_ADDR[31:4]);
    assign w_wr         = bus.memwrite & w_sel;
    assign w_wr_ctrl    = w_wr & (bus.dataadr[3:2] == 2'd0);
    assign w_wr_count   = w_wr & (bus.dataadr[3:2] == 2'd1);
    assign w_wr_compare = w_wr & (bus.dataadr[3:2] == 2'd2);
    assign w_wr_status  = w_wr & (bus.dataadr[3:2] == 2'd3);

    // Enable as it will be after this edge; a store clearing en suppresses
    // a tick that would otherwise land on the same edge.
    assign w_en_next = w_wr_ctrl ? bus.writedata[0] : r_en;
    assign w_tick    = r_en & w_en_next & (r_presc == PRESC_LAST);
    // Match always looks at the pre-edge COUNT and COMPARE.
    assign w_hit     = w_tick & (r_count == r_compare);

    assign irq     = r_match & r_irq_en;
    assign bus.sel = w_sel;

    // Combinational read mux; returns zero outside the window.
    always_comb begin
        w_readdata = 32'd0;
        if (w_sel) begin
            case (bus.dataadr[3:2])
                2'd0:    w_readdata = {29'd0, r_irq_en, r_autoreload, r_en};
                2'd1:    w_readdata = r_count;
                2'd2:    w_readdata = r_compare;
                2'd3:    w_readdata = {31'd0, r_match};
                default: w_readdata = 32'd0;
            endcase
        end else begin
            w_readdata = 32'd0;
        end
    end

    assign bus.readdata = w_readdata;

    // Register file, prescaler, counter and match flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en         <= 1'b0;
            r_autoreload <= 1'b0;
            r_irq_en     <= 1'b0;
            r_match      <= 1'b0;
            r_count      <= 32'd0;
            r_compare    <= 32'hFFFF_FFFF;
            r_presc      <= 16'd0;
        end else begin
            if (w_wr_ctrl) begin
                r_en         <= bus.writedata[0];
                r_autoreload <= bus.writedata[1];
                r_irq_en     <= bus.writedata[2];
            end

            // Held at zero while disabled, so a fresh enable starts a full period.
            if (!r_en || !w_en_next || w_tick) begin
                r_presc <= 16'd0;
            end else begin
                r_presc <= r_presc + 16'd1;
            end

            // A CPU store to COUNT overrides both reload and increment.
            if (w_wr_count) begin
                r_count <= bus.writedata;
            end else if (w_hit && r_autoreload) begin
                r_count <= 32'd0;
            end else if (w_tick) begin
                r_count <= r_count + 32'd1;
            end

            if (w_wr_compare) begin
                r_compare <= bus.writedata;
            end

            // A new match beats a simultaneous write-1-to-clear.
            if (w_hit) begin
                r_match <= 1'b1;
            end else if (w_wr_status && bus.writedata[0]) begin
                r_match <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] OUTA = 32'h0000_0200;
    localparam int          DIV  = 4;

    logic clk = 1'b0;
    logic reset;
    logic irq;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mmio_timer_if bus ();

    mmio_timer #(.BASE_ADDR(BASE), .PRESC_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    // Reference model: architectural registers plus the number of
    // consecutive enabled cycles since the timer was last enabled.
    bit          m_en, m_ar, m_ie, m_match;
    logic [31:0] m_count, m_cmp;
    int          m_run;

    function automatic bit m_in_window(logic [31:0] adr);
        logic [31:0] b;
        b = BASE;
        return adr[31:4] == b[31:4];
    endfunction

    function automatic bit m_tick_pending();
        return m_en && (((m_run + 1) % DIV) == 0);
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] adr);
        if (!m_in_window(adr)) return 32'd0;
        case (adr[3:2])
            2'd0:    return {29'd0, m_ie, m_ar, m_en};
            2'd1:    return m_count;
            2'd2:    return m_cmp;
            default: return {31'd0, m_match};
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit we, input logic [31:0] adr, input logic [31:0] wd);
        bit w, tick, hit, new_en;
        logic [31:0] nc;
        if (rst) begin
            m_en = 0; m_ar = 0; m_ie = 0; m_match = 0;
            m_count = 32'd0; m_cmp = 32'hFFFF_FFFF; m_run = 0;
            return;
        end
        w      = we && m_in_window(adr);
        new_en = (w && adr[3:2] == 2'd0) ? wd[0] : m_en;
        tick   = m_en && new_en && (((m_run + 1) % DIV) == 0);
        hit    = tick && (m_count == m_cmp);
        nc     = m_count;
        if (tick) nc = (hit && m_ar) ? 32'd0 : m_count + 32'd1;
        if (w && adr[3:2] == 2'd1) nc = wd;
        if (hit) m_match = 1;
        else if (w && adr[3:2] == 2'd3 && wd[0]) m_match = 0;
        if (w && adr[3:2] == 2'd2) m_cmp = wd;
        m_run   = (m_en && new_en) ? m_run + 1 : 0;
        m_count = nc;
        if (w && adr[3:2] == 2'd0) begin
            m_en = wd[0]; m_ar = wd[1]; m_ie = wd[2];
        end
    endtask

    // One clock edge with the given bus activity; returns 1 time unit after the edge.
    task automatic drive(input bit rst, input bit we, input logic [31:0] adr, input logic [31:0] wd);
        reset         = rst;
        bus.memwrite  = we;
        bus.dataadr   = adr;
        bus.writedata = wd;
        @(posedge clk);
        model_step(rst, we, adr, wd);
        #1;
        reset        = 1'b0;
        bus.memwrite = 1'b0;
        bus.dataadr  = OUTA;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, OUTA, 32'd0);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] v);
        bus.dataadr = adr;
        #1;
        v = bus.readdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] exp_r [4];
        exp_r[0] = 32'd0; exp_r[1] = 32'd0; exp_r[2] = 32'hFFFF_FFFF; exp_r[3] = 32'd0;
        drive(1'b1, 1'b0, OUTA, 32'd0);
        drive(1'b1, 1'b0, OUTA, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 32'(i * 4), v);
            n_checks++;
            if (v !== exp_r[i]) begin
                n_fail++; $display("FAIL reset_reg%0d: got %h expected %h", i, v, exp_r[i]);
            end
        end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        rd(OUTA, v);
        n_checks++;
        if (v !== 32'd0 || bus.sel !== 1'b0) begin
            n_fail++; $display("FAIL out_of_window: readdata %h sel %b expected 0/0", v, bus.sel);
        end
        rd(BASE + 32'h4, v);
        n_checks++;
        if (bus.sel !== 1'b1) begin n_fail++; $display("FAIL in_window_sel: got %b expected 1", bus.sel); end
    endtask

    task automatic test_autoreload();
        logic [31:0] v, s;
        drive(1'b0, 1'b1, BASE + 32'h8, 32'd3);
        drive(1'b0, 1'b1, BASE, 32'd7);
        for (int k = 0; k < 48; k++) begin
            idle();
            rd(BASE + 32'h4, v);
            rd(BASE + 32'hC, s);
            n_checks++;
            if (v !== m_read(BASE + 32'h4) || s !== m_read(BASE + 32'hC) || irq !== (m_match & m_ie)) begin
                n_fail++;
                $display("FAIL autoreload_model k=%0d: count %h status %h irq %b expected %h %h %b",
                         k, v, s, irq, m_count, m_match, m_match & m_ie);
            end
            if (k == 3 || k == 11 || k == 14 || k == 15 || k == 31) begin
                n_checks++;
                if ((k == 3  && v !== 32'd1) || (k == 11 && v !== 32'd3) ||
                    (k == 14 && (v !== 32'd3 || irq !== 1'b0)) ||
                    (k == 15 && (v !== 32'd0 || s !== 32'd1 || irq !== 1'b1)) ||
                    (k == 31 && (v !== 32'd0 || irq !== 1'b1))) begin
                    n_fail++;
                    $display("FAIL autoreload_point k=%0d: count %h status %h irq %b", k, v, s, irq);
                end
            end
        end
    endtask

    task automatic test_w1c();
        logic [31:0] s;
        bit found;
        drive(1'b0, 1'b1, BASE + 32'hC, 32'd0);
        rd(BASE + 32'hC, s);
        n_checks++;
        if (s !== 32'd1) begin n_fail++; $display("FAIL w1c_write0: got %h expected 1", s); end
        drive(1'b0, 1'b1, BASE + 32'hC, 32'd1);
        rd(BASE + 32'hC, s);
        n_checks++;
        if (s !== 32'd0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL w1c_clear: status %h irq %b expected 0/0", s, irq);
        end
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_tick_pending() && m_count == m_cmp) found = 1;
            else idle();
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL w1c_wait: no match within bound, got none expected one");
        end else begin
            drive(1'b0, 1'b1, BASE + 32'hC, 32'd1);
            rd(BASE + 32'hC, s);
            if (s !== 32'd1 || irq !== 1'b1) begin
                n_fail++; $display("FAIL w1c_vs_set: status %h irq %b expected 1/1", s, irq);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] v, s;
        drive(1'b0, 1'b1, BASE, 32'd0);
        drive(1'b0, 1'b1, BASE + 32'hC, 32'd1);
        drive(1'b0, 1'b1, BASE + 32'h4, 32'hFFFF_FFFE);
        drive(1'b0, 1'b1, BASE + 32'h8, 32'd5);
        drive(1'b0, 1'b1, BASE, 32'd1);
        for (int k = 0; k < 36; k++) begin
            idle();
            rd(BASE + 32'h4, v);
            rd(BASE + 32'hC, s);
            n_checks++;
            if (v !== m_count || s !== {31'd0, m_match} || irq !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_model k=%0d: count %h status %h irq %b expected %h %h 0", k, v, s, irq, m_count, m_match);
            end
            if (k == 3 || k == 7 || k == 27 || k == 31) begin
                n_checks++;
                if ((k == 3  && v !== 32'hFFFF_FFFF) || (k == 7 && v !== 32'd0) ||
                    (k == 27 && (v !== 32'd5 || s !== 32'd0)) ||
                    (k == 31 && (v !== 32'd6 || s !== 32'd1))) begin
                    n_fail++; $display("FAIL wrap_point k=%0d: count %h status %h", k, v, s);
                end
            end
        end
    endtask

    task automatic test_count_collision();
        logic [31:0] v;
        bit found;
        found = 0;
        for (int k = 0; k < 8 && !found; k++) begin
            if (m_tick_pending()) found = 1;
            else idle();
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL collision_wait: no tick within bound, got none expected one");
        end else begin
            drive(1'b0, 1'b1, BASE + 32'h4, 32'h50);
            rd(BASE + 32'h4, v);
            if (v !== 32'h50 || v !== m_count) begin
                n_fail++; $display("FAIL count_write_vs_tick: got %h expected 00000050", v);
            end
        end
    endtask

    task automatic test_enable_toggle();
        logic [31:0] v, v0;
        bit found;
        found = 0;
        for (int k = 0; k < 8 && !found; k++) begin
            if (m_en && (m_run % DIV) == 1) found = 1;
            else idle();
        end
        drive(1'b0, 1'b1, BASE, 32'd0);
        v0 = m_count;
        for (int k = 0; k < 10; k++) idle();
        rd(BASE + 32'h4, v);
        n_checks++;
        if (!found || v !== v0) begin
            n_fail++; $display("FAIL disable_freeze: got %h expected %h (found=%0d)", v, v0, found);
        end
        drive(1'b0, 1'b1, BASE, 32'd1);
        for (int k = 0; k < DIV; k++) begin
            idle();
            rd(BASE + 32'h4, v);
            n_checks++;
            if (v !== ((k == DIV - 1) ? v0 + 32'd1 : v0) || v !== m_count) begin
                n_fail++; $display("FAIL reenable_tick k=%0d: got %h model %h", k, v, m_count);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] v, adr, wd;
        bit rst, we;
        int r, off;
        for (int n = 0; n < 400; n++) begin
            r   = $urandom_range(0, 99);
            rst = (r < 2);
            we  = (r >= 2 && r < 45);
            off = $urandom_range(0, 3);
            adr = ($urandom_range(0, 9) == 0) ? OUTA + 32'(off * 4) : BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
            wd  = $urandom;
            if (off == 0 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
            if ((off == 1 || off == 2) && $urandom_range(0, 3) != 0) wd = 32'($urandom_range(0, 12));
            drive(rst, we, adr, wd);
            for (int i = 0; i < 4; i++) begin
                rd(BASE + 32'(i * 4), v);
                n_checks++;
                if (v !== m_read(BASE + 32'(i * 4))) begin
                    n_fail++; $display("FAIL random_reg%0d n=%0d: got %h expected %h", i, n, v, m_read(BASE + 32'(i * 4)));
                end
            end
            n_checks++;
            if (irq !== (m_match & m_ie)) begin
                n_fail++; $display("FAIL random_irq n=%0d: got %b expected %b", n, irq, m_match & m_ie);
            end
        end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] v;
        logic [31:0] exp_r [4];
        exp_r[0] = 32'd0; exp_r[1] = 32'd0; exp_r[2] = 32'hFFFF_FFFF; exp_r[3] = 32'd0;
        drive(1'b0, 1'b1, BASE, 32'd0);
        drive(1'b0, 1'b1, BASE + 32'h4, 32'd0);
        drive(1'b0, 1'b1, BASE + 32'h8, 32'd2);
        drive(1'b0, 1'b1, BASE + 32'hC, 32'd1);
        drive(1'b0, 1'b1, BASE, 32'd7);
        for (int k = 0; k < 64 && !m_match; k++) idle();
        rd(BASE + 32'hC, v);
        n_checks++;
        if (v !== 32'd1 || irq !== 1'b1) begin
            n_fail++; $display("FAIL premreset_match: status %h irq %b expected 1/1", v, irq);
        end
        drive(1'b1, 1'b1, BASE + 32'h4, 32'h1234);
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 32'(i * 4), v);
            n_checks++;
            if (v !== exp_r[i]) begin
                n_fail++; $display("FAIL midreset_reg%0d: got %h expected %h", i, v, exp_r[i]);
            end
        end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_irq: got %b expected 0", irq); end
    endtask

    initial begin
        reset         = 1'b1;
        bus.memwrite  = 1'b0;
        bus.dataadr   = OUTA;
        bus.writedata = 32'd0;
        m_en = 0; m_ar = 0; m_ie = 0; m_match = 0;
        m_count = 32'd0; m_cmp = 32'hFFFF_FFFF; m_run = 0;
        test_reset();
        test_autoreload();
        test_w1c();
        test_wrap();
        test_count_collision();
        test_enable_toggle();
        test_random();
        test_reset_midcount();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
